// File: rtl/bvshr_inverse_solver.sv
// ---------------------------------------------------------------------------
// bvshr_inverse_solver
//
// Purpose:
//   Sequential Skolem-function engine for right shifts. Given a shift amount s
//   and a target t, it decides whether some x exists with (x OP s) == t. When
//   one exists, it emits a witness x. OP is chosen per request: arithmetic
//   right shift (ashr) or logical right shift (lshr). Requests arrive and
//   results leave on valid/ready streams.
//
//   One bit-check is done per cycle on a working copy of t. Early exit on the
//   first failed check is optional.
//
// Optional feature:
//   SKOLEM_SHL_INV_EN - when defined, op=2 solves (x << s) == t.
//                       When undefined, op=2 is treated like the illegal op=3.
//
// Parameters:
//   W          operand width in bits (>= 2)
//   EARLY_EXIT 1: stop checking on the first failure; 0: always run all checks
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   high only while idle
//   in_op      0=ashr, 1=lshr, 2=shl (feature build only), 3=illegal
//   in_s       shift amount (unsigned)
//   in_t       target value
//   out_valid  result valid, held until out_ready
//   out_ready  result accepted
//   out_sat    1 when the invertibility condition holds
//   out_x      witness when out_sat=1, otherwise zero
// ---------------------------------------------------------------------------
module bvshr_inverse_solver #(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sat,
  output logic [W-1:0] out_x
);

  // The check counter must be able to hold W itself (lshr/shl with s >= W).
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t         state;
  logic [1:0]     op_r;
  logic [W-1:0]   s_r;
  logic [W-1:0]   t_r;
  logic [W-1:0]   work;
  logic [CW-1:0]  cnt;
  logic           sat_r;

  logic           in_s_ge_w;
  logic           in_s_ge_wm1;
  logic           in_legal;
  logic [CW-1:0]  n_in;
  logic           s_r_ge_w;
  logic           check_ok;
  logic [W-1:0]   work_next;
  logic [W-1:0]   x_sat;

  // Decode an incoming request into its number of checks and a legality flag.
  // The shift amount is zero-extended by one bit before comparison. This
  // keeps the compare against W exact, even for the smallest widths.
  // Illegal ops get zero checks, so they pass straight through SHIFT.
  always_comb begin
    in_s_ge_w   = ({1'b0, in_s} >= (W+1)'(W));
    in_s_ge_wm1 = ({1'b0, in_s} >= (W+1)'(W - 1));
    in_legal    = 1'b0;
    n_in        = '0;
    case (in_op)
      2'd0: begin
        in_legal = 1'b1;
        n_in     = in_s_ge_wm1 ? CW'(W - 1) : CW'(in_s);
      end
      2'd1: begin
        in_legal = 1'b1;
        n_in     = in_s_ge_w ? CW'(W) : CW'(in_s);
      end
`ifdef SKOLEM_SHL_INV_EN
      2'd2: begin
        in_legal = 1'b1;
        n_in     = in_s_ge_w ? CW'(W) : CW'(in_s);
      end
`endif
      default: begin
        in_legal = 1'b0;
        n_in     = '0;
      end
    endcase
  end

  // Per-cycle check on the working copy, and the copy's next value.
  // For ashr, each step checks that the top two bits agree. That is the
  // sign-extension pattern an arithmetic shift would have produced.
  // For lshr, each step checks that the top bit is zero.
  // For shl, the copy walks the other way, and the bottom bit must be zero.
  always_comb begin
    check_ok  = 1'b1;
    work_next = work << 1;
    case (op_r)
      2'd0: check_ok = (work[W-1] == work[W-2]);
      2'd1: check_ok = ~work[W-1];
`ifdef SKOLEM_SHL_INV_EN
      2'd2: begin
        check_ok  = ~work[0];
        work_next = work >> 1;
      end
`endif
      default: check_ok = 1'b1;
    endcase
  end

  // Witness assuming the condition holds.
  // For right shifts, x = t << s undoes the shift. When s >= W, t is all-0 or
  // all-1, or it is 0 for lshr. In that case t itself is a valid preimage.
  // For shl, x = t >> s, which is naturally zero once s >= W.
  always_comb begin
    s_r_ge_w = ({1'b0, s_r} >= (W+1)'(W));
    x_sat    = s_r_ge_w ? t_r : (t_r << s_r);
`ifdef SKOLEM_SHL_INV_EN
    if (op_r == 2'd2) begin
      x_sat = t_r >> s_r;
    end
`endif
  end

  // Main controller: IDLE -> SHIFT -> DONE -> IDLE.
  // SHIFT does one check per cycle while cnt is non-zero. It enters DONE on
  // the edge where cnt is already zero, so n checks take n+1 cycles.
  // An early-exit failure forces cnt to zero, so DONE follows on the next
  // edge. out_sat and out_x load only on entry to DONE. They then hold
  // through backpressure and the following idle period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      out_x     <= '0;
      op_r      <= '0;
      s_r       <= '0;
      t_r       <= '0;
      work      <= '0;
      cnt       <= '0;
      sat_r     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_r     <= in_op;
            s_r      <= in_s;
            t_r      <= in_t;
            work     <= in_t;
            cnt      <= n_in;
            sat_r    <= in_legal;
            in_ready <= 1'b0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == '0) begin
            out_valid <= 1'b1;
            out_sat   <= sat_r;
            out_x     <= sat_r ? x_sat : '0;
            state     <= ST_DONE;
          end else begin
            work <= work_next;
            cnt  <= cnt - 1'b1;
            if (!check_ok) begin
              sat_r <= 1'b0;
              if (EARLY_EXIT) begin
                cnt <= '0;
              end
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bvshr_inverse_solver.sv
// ---------------------------------------------------------------------------
// tb_bvshr_inverse_solver
//
// Purpose:
//   Self-checking bench for bvshr_inverse_solver with W=8 and EARLY_EXIT=1.
//   A behavioural model computes the expected sat flag, witness and latency
//   from the shift-inversion rules, using plain integer arithmetic.
//   The bench runs directed corner cases and then randomized requests.
// ---------------------------------------------------------------------------
module tb_bvshr_inverse_solver;

  localparam int W  = 8;
  localparam bit EE = 1'b1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic         out_valid;
  logic         out_ready;
  logic         out_sat;
  logic [W-1:0] out_x;

  int total = 0;
  int bad   = 0;

  bvshr_inverse_solver #(.W(W), .EARLY_EXIT(EE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_s      (in_s),
    .in_t      (in_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .out_x     (out_x)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model built from the shift-inversion rules.
  // A preimage of (x >>> s) exists iff the kept top bits of t are a sign
  // extension. A preimage of (x >> s) exists iff the vacated top bits are 0.
  // A preimage of (x << s) exists iff the vacated low bits are 0.
  // For latency, the k-th check looks at a fixed bit pair (or bit) of the
  // original t. It is the first such failure that ends the run early.
  function automatic void refModel(input int op, input int s, input int t,
                                   output int sat, output int x, output int lat);
    int n;
    int fail;
    int top;
    int mask;
    mask = (1 << W) - 1;
    n    = 0;
    fail = 0;
    sat  = 0;
    x    = 0;
    if (op == 0) begin
      n = (s < W - 1) ? s : W - 1;
      if (s < W) begin
        top = t >> (W - 1 - s);
        sat = (top == 0 || top == (1 << (s + 1)) - 1) ? 1 : 0;
      end else begin
        sat = (t == 0 || t == mask) ? 1 : 0;
      end
      for (int k = 1; k <= n; k++)
        if (fail == 0 && ((t >> (W - k)) & 1) != ((t >> (W - k - 1)) & 1)) fail = k;
      if (sat == 1) x = (s < W) ? ((t << s) & mask) : t;
    end else if (op == 1) begin
      n   = (s < W) ? s : W;
      sat = ((t >> (W - n)) == 0) ? 1 : 0;
      for (int k = 1; k <= n; k++)
        if (fail == 0 && ((t >> (W - k)) & 1) != 0) fail = k;
      if (sat == 1) x = (s < W) ? ((t << s) & mask) : t;
`ifdef SKOLEM_SHL_INV_EN
    end else if (op == 2) begin
      n   = (s < W) ? s : W;
      sat = ((t & ((1 << n) - 1)) == 0) ? 1 : 0;
      for (int k = 1; k <= n; k++)
        if (fail == 0 && ((t >> (k - 1)) & 1) != 0) fail = k;
      if (sat == 1) x = (s < W) ? (t >> s) : 0;
`endif
    end
    lat = (EE && fail != 0) ? fail + 1 : n + 1;
  endfunction

  // Issue one request and check latency and result against the model.
  // Then hold backpressure for 'hold' cycles, pulsing a stray request that
  // must be ignored. Finally complete the handshake.
  task automatic applyStimulus(input int op, input int s, input int t, input int hold);
    int esat;
    int ex;
    int elat;
    int lat;
    refModel(op, s, t, esat, ex, elat);
    @(negedge clk);
    checkOutput("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_op    = op[1:0];
    in_s     = s[W-1:0];
    in_t     = t[W-1:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_s     = W'($urandom);
    in_t     = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput($sformatf("latency op=%0d s=%0h t=%0h", op, s, t), lat, elat);
    checkOutput($sformatf("sat op=%0d s=%0h t=%0h", op, s, t), out_sat, esat);
    checkOutput($sformatf("x op=%0d s=%0h t=%0h", op, s, t), out_x, ex);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (i == 1);
      in_op     = 2'($urandom);
      in_s      = W'($urandom);
      in_t      = W'($urandom);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_sat", out_sat, esat);
      checkOutput("bp_x", out_x, ex);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("hs_out_valid", out_valid, 0);
    checkOutput("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int op;
    int s;
    int t;
    int r;
    logic [W-1:0] r8;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_s      = '0;
    in_t      = '0;
    out_ready = 1'b0;
    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sat", out_sat, 0);
    checkOutput("rst_x", out_x, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    applyStimulus(0, 2, 8'hE5, 0);
    applyStimulus(0, 3, 8'hD0, 0);
    applyStimulus(0, 8'hFF, 8'hFF, 0);
    applyStimulus(0, 8'hFF, 8'h7F, 0);
    applyStimulus(1, 9, 8'h00, 0);
    applyStimulus(1, 9, 8'h01, 0);
    applyStimulus(0, 0, 8'h5A, 0);
    applyStimulus(1, 0, 8'h5A, 0);
    applyStimulus(3, 2, 8'hE5, 0);
    applyStimulus(2, 2, 8'h14, 0);
    applyStimulus(2, 2, 8'h16, 0);
    applyStimulus(1, 7, 8'h01, 0);
    applyStimulus(0, 7, 8'h80, 0);
    applyStimulus(1, 8, 8'h00, 0);

    // Backpressure with a stray request, leaving sat=1 and x non-zero.
    applyStimulus(0, 2, 8'hE5, 5);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_s     = 8'd7;
    in_t     = 8'h00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_sat", out_sat, 0);
    checkOutput("midrst_x", out_x, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 2, 8'hE5, 0);

    // Randomized requests, biased toward satisfiable targets.
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 3));
      s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 9));
      r  = int'($urandom_range(0, 255));
      r8 = r[W-1:0];
      case ($urandom_range(0, 3))
        0:       t = r;
        1:       t = (s < W) ? (r >> s) : 0;
        2:       begin r8 = $signed(r8) >>> ((s < W) ? s : W - 1); t = int'(r8); end
        default: t = (r << ((s < W) ? s : W)) & 8'hFF;
      endcase
      applyStimulus(op, s, t, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
